// File: rtl/clmul_pkg.sv
// Shared types and helpers for the iterative carry-less multiplier.
//   clmul_mode_t  : result selection (low half, high half, reversed window)
//   clmul_state_t : controller states
//   iter_max()    : worst-case RUN cycles for a given width and step
package clmul_pkg;

  typedef enum logic [1:0] {
    CLMUL_LO  = 2'b00,
    CLMUL_HI  = 2'b01,
    CLMUL_REV = 2'b10
  } clmul_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } clmul_state_t;

  function automatic int iter_max(input int xlen, input int step);
    return xlen / step;
  endfunction

endpackage

// File: rtl/clmul_step.sv
// One iteration of the carry-less multiply: XOR of a_sh shifted by every set
// bit of the current multiplier chunk.
//   a_sh    : shifted multiplicand (2*XLEN)
//   b_chunk : low STEP bits of the remaining multiplier
//   part    : partial product to XOR into the accumulator (2*XLEN)
module clmul_step
  import clmul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [2*XLEN-1:0] a_sh,
  input  logic [STEP-1:0]   b_chunk,
  output logic [2*XLEN-1:0] part
);

  always_comb begin
    part = '0;
    for (int j = 0; j < STEP; j++) begin
      if (b_chunk[j]) part = part ^ (a_sh << j);
    end
  end

endmodule

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR) with STEP
// multiplier bits per cycle and early exit once the remaining multiplier is 0.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : launch; accepted in IDLE or DONE when stall=0
//   stall        : freezes all state and outputs
//   mode         : 00 low, 01 high, 10 reversed, 11 treated as low
//   a, b         : multiplicand / multiplier, captured on accepted start
//   busy, done   : RUN / DONE indication
//   res          : selected result, registered on entry to DONE
//
// state | meaning
// IDLE  | waiting for start
// RUN   | consuming STEP multiplier bits per non-stalled cycle
// DONE  | result valid on res; leaves when stall=0
module clmul_unit
  import clmul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stall,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int ITER_MAX = iter_max(XLEN, STEP);

  if (!((XLEN == 32 || XLEN == 64) &&
        (STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8) &&
        (ITER_MAX * STEP == XLEN))) begin : g_param_err
    $error("clmul_unit: illegal XLEN/STEP combination");
  end

  clmul_state_t      state, state_nxt;
  logic [2*XLEN-1:0] acc, a_sh, part, acc_nxt;
  logic [XLEN-1:0]   b_sh, res_nxt;
  logic [1:0]        mode_q;
  logic              load, adv, fin, last;

  clmul_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .a_sh    (a_sh),
    .b_chunk (b_sh[STEP-1:0]),
    .part    (part)
  );

  assign acc_nxt = acc ^ part;
  // Nothing left above the current chunk: this iteration finishes the product.
  assign last    = ((b_sh >> STEP) == '0);

  always_comb begin
    case (mode_q)
      CLMUL_HI:  res_nxt = acc_nxt[2*XLEN-1:XLEN];
      CLMUL_REV: res_nxt = acc_nxt[2*XLEN-2:XLEN-1];
      default:   res_nxt = acc_nxt[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stall) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          adv = 1'b1;
          if (last) begin
            fin       = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (!stall) begin
          if (start) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      mode_q <= '0;
      res    <= '0;
    end else begin
      if (load) begin
        acc    <= '0;
        a_sh   <= {{XLEN{1'b0}}, a};
        b_sh   <= b;
        mode_q <= mode;
      end else if (adv) begin
        acc    <= acc_nxt;
        a_sh   <= a_sh << STEP;
        b_sh   <= b_sh >> STEP;
      end
      if (fin) res <= res_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_clmul_unit.sv
module tb_clmul_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stall;
  logic [1:0]  mode;
  logic [31:0] a, b, res;
  logic        busy, done;

  logic        start64, stall64;
  logic [1:0]  mode64;
  logic [63:0] a64, b64, res64;
  logic        busy64, done64;

  int total = 0;
  int bad   = 0;
  int n;
  logic [31:0] exp_r;

  always #5 clk = ~clk;

  clmul_unit #(.XLEN(32), .STEP(4)) u32 (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall), .mode(mode),
    .a(a), .b(b), .busy(busy), .done(done), .res(res)
  );

  clmul_unit #(.XLEN(64), .STEP(8)) u64 (
    .clk(clk), .reset_n(reset_n), .start(start64), .stall(stall64), .mode(mode64),
    .a(a64), .b(b64), .busy(busy64), .done(done64), .res(res64)
  );

  function automatic logic [31:0] ref_clmul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] m);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (y[i]) p = p ^ ({32'b0, x} << i);
    case (m)
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return p[31:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
    a = x; b = y; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // counts RUN cycles until the 32-bit unit leaves RUN (bounded)
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; stall = 0; mode = 0; a = 0; b = 0;
    start64 = 0; stall64 = 0; mode64 = 0; a64 = 0; b64 = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", res, 0);
    chk("rst_busy64", busy64, 0);
    chk("rst_done64", done64, 0);
    chk("rst_res64", res64, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 3 x 3 -> 5 in one RUN cycle
    launch(32'd3, 32'd3, 2'b00);
    chk("small_busy", busy, 1);
    wait_done(n);
    chk("small_cycles", n, 1);
    chk("small_done", done, 1);
    chk("small_res", res, 32'h5);
    tick();
    chk("small_idle_done", done, 0);
    chk("small_idle_busy", busy, 0);

    // mode selection on a single high product bit
    launch(32'h8000_0000, 32'h2, 2'b00);
    wait_done(n);
    chk("msb_lo", res, 32'h0);
    tick();
    launch(32'h8000_0000, 32'h2, 2'b01);
    wait_done(n);
    chk("msb_hi", res, 32'h1);
    tick();
    launch(32'h8000_0000, 32'h2, 2'b10);
    wait_done(n);
    chk("msb_rev", res, 32'h2);
    tick();
    launch(32'h8000_0000, 32'h2, 2'b11);
    wait_done(n);
    chk("msb_rsvd", res, 32'h0);
    tick();

    // worst case; start held (with other operands) during RUN is ignored
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; mode = 2'b01; start = 1'b1;
    tick();
    a = 32'h0; b = 32'h1; mode = 2'b00;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ones_cycles", n + 1, 8);
    chk("ones_done", done, 1);
    chk("ones_res", res, 32'h5555_5555);
    tick();

    // stall in RUN, then stall in DONE
    exp_r = ref_clmul(32'h1234_5678, 32'h9ABC_DEF0, 2'b00);
    launch(32'h1234_5678, 32'h9ABC_DEF0, 2'b00);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_run_busy", busy, 1);
      chk("stall_run_done", done, 0);
    end
    stall = 1'b0;
    wait_done(n);
    chk("stall_run_cycles", n, 7);
    chk("stall_run_res", res, exp_r);
    stall = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_done_done", done, 1);
      chk("stall_done_res", res, exp_r);
    end
    stall = 1'b0;
    start = 1'b0;
    tick();
    chk("stall_exit_done", done, 0);

    // b = 0 then back-to-back start from DONE
    launch(32'h0000_1234, 32'h0, 2'b00);
    wait_done(n);
    chk("bzero_cycles", n, 1);
    chk("bzero_res", res, 32'h0);
    launch(32'd3, 32'd3, 2'b00);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    wait_done(n);
    chk("b2b_res", res, 32'h5);
    tick();

    // asynchronous reset mid-RUN
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_res", res, 0);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("arst_no_done", done, 0);
    chk("arst_idle", busy, 0);
    launch(32'h8000_0000, 32'h2, 2'b10);
    wait_done(n);
    chk("arst_next_res", res, 32'h2);
    tick();

    // 64-bit, 8 bits per cycle
    a64 = '1; b64 = '1; mode64 = 2'b00; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    n = 0;
    while (busy64 && n < 100) begin
      tick();
      n++;
    end
    chk("x64_cycles", n, 8);
    chk("x64_done", done64, 1);
    chk("x64_res", res64, 64'h5555_5555_5555_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
